// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXEC/WB/HALT) for a small
// accumulator CPU, with registered strobes and a saturating retired counter.
module seq_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        inst_reg,
  output logic              alu_en,
  input  logic              carry,
  input  logic              zero,
  output logic              w_we,
  output logic              halt,
  output logic [16:0]       retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

  localparam logic [16:0] RETIRED_MAX = 17'h1FFFF;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              c_flag;
  logic              z_flag;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == RETIRED_MAX) ? v : v + 17'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] v);
    return v + ADDR_W'(1);
  endfunction

  assign mem_addr = pc;

  // Strobes are registered from the next state, so mem_req stays low in the
  // first FETCH cycle after reset and an ack there is not accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= '0;
      inst_reg <= 8'h00;
      c_flag   <= 1'b0;
      z_flag   <= 1'b0;
      retired  <= '0;
      alu_en   <= 1'b0;
      w_we     <= 1'b0;
      halt     <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      alu_en  <= 1'b0;
      w_we    <= 1'b0;
      mem_req <= 1'b0;
      unique case (state)
        FETCH: begin
          if (mem_req && mem_ack) begin
            inst_reg <= mem_data;
            pc       <= pc_inc(pc);
            state    <= DECODE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        DECODE: begin
          case (inst_reg[7:6])
            2'b00: begin
              state  <= EXEC;
              alu_en <= 1'b1;
            end
            2'b01: begin
              pc      <= ADDR_W'(inst_reg[5:0]);
              state   <= FETCH;
              mem_req <= 1'b1;
              retired <= sat_inc(retired);
            end
            2'b10: begin
              if (inst_reg[5] ? z_flag : c_flag) pc <= pc_inc(pc);
              state   <= FETCH;
              mem_req <= 1'b1;
              retired <= sat_inc(retired);
            end
            default: begin
              state   <= HALT;
              halt    <= 1'b1;
              retired <= sat_inc(retired);
            end
          endcase
        end
        EXEC: begin
          state <= WB;
          w_we  <= 1'b1;
        end
        WB: begin
          c_flag  <= carry;
          z_flag  <= zero;
          state   <= FETCH;
          mem_req <= 1'b1;
          retired <= sat_inc(retired);
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the program-memory address width.
REQ-002 The block SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port mem_req  output  1  instruction fetch request.
REQ-005 The block SHALL have port mem_addr  output  ADDR_W  fetch address, equal to the current pc.
REQ-006 The block SHALL have port mem_ack  input  1  memory handshake, mem_data valid when high.
REQ-007 The block SHALL have port mem_data  input  8  fetched instruction byte.
REQ-008 The block SHALL have port inst_reg  output  8  latched instruction, fed to the decoder.
REQ-009 The block SHALL have port alu_en  output  1  one-cycle execute strobe to the ALU.
REQ-010 The block SHALL have port carry  input  1  ALU carry (ans[8]).
REQ-011 The block SHALL have port zero  input  1  ALU result-is-zero flag.
REQ-012 The block SHALL have port w_we  output  1  one-cycle W-register write enable.
REQ-013 The block SHALL have port halt  output  1  high while in HALT.
REQ-014 The block SHALL have port retired  output  17  count of completed instructions.

Function
REQ-015 The block SHALL implement the states FETCH, DECODE, EXEC, WB and HALT.
REQ-016 FETCH SHALL behave as follows:
- mem_req=1 and mem_addr=pc.
- Stay in FETCH while mem_ack=0.
- On mem_ack=1: inst_reg<=mem_data, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), next state DECODE.
REQ-017 mem_req SHALL be low in every state except FETCH, and mem_data SHALL be ignored outside FETCH.
REQ-018 DECODE SHALL take one cycle and dispatch on inst_reg[7:6]:
- 00 ALU op -> EXEC.
- 01 JMP -> pc<=zero-extended inst_reg[5:0], next FETCH.
- 10 SKIP -> condition is c_flag if inst_reg[5]=0, z_flag if inst_reg[5]=1; if true pc<=pc+1 (wrapping); next FETCH.
- 11 HLT -> HALT.
REQ-019 EXEC SHALL assert alu_en=1 for exactly one cycle, then go to WB.
REQ-020 WB SHALL assert w_we=1 for exactly one cycle, set c_flag<=carry and z_flag<=zero, then go to FETCH.
REQ-021 c_flag and z_flag SHALL change only in WB; JMP, SKIP and HLT SHALL leave them unchanged.
REQ-022 retired SHALL increment by 1 on leaving WB, on JMP/SKIP completion in DECODE, and on entry to HALT; it SHALL saturate at 17'h1FFFF.
REQ-023 HALT SHALL be absorbing: halt=1, all strobes low, pc and inst_reg frozen, exit only by reset.
REQ-024 Latency SHALL be:
- ALU instruction with mem_ack in the first FETCH cycle: 4 cycles from FETCH entry to the next FETCH entry.
- JMP/SKIP: 2 cycles.
- Each cycle of mem_ack=0 adds 1 cycle.
REQ-025 alu_en and w_we SHALL never be high in the same cycle, and each SHALL be high at most once per instruction.

Reset
REQ-026 While reset=0 the block SHALL asynchronously force the following, and hold them while reset is low:
- state=FETCH, pc=0, inst_reg=8'h00.
- c_flag=0, z_flag=0, retired=0.
- alu_en=0, w_we=0, halt=0, mem_req=0.
REQ-027 On the first rising clk edge after reset deasserts, the block SHALL assert mem_req with mem_addr=0.
REQ-028 Reset asserted mid-instruction (any state) SHALL abort that instruction without issuing a further alu_en or w_we pulse.

Verification
REQ-029 Zero-wait ALU op: reset release, mem_data=8'h1D, mem_ack=1 constantly -> alu_en in cycle 3, w_we in cycle 4, mem_addr=1 in cycle 5, retired=1.
REQ-030 Wait states: mem_ack held low 3 cycles in FETCH -> mem_req stays 1, mem_addr stable, inst_reg updates only on the ack cycle.
REQ-031 JMP and wrap: program 8'h7F (JMP 63); also pc=255 (ADDR_W=8) fetch -> next mem_addr=0.
REQ-032 SKIP: WB with carry=1 then SKIP 8'h80 -> next fetch address advances by 2; same with carry=0 -> advances by 1; 8'hA0 tests z_flag.
REQ-033 HLT: fetch 8'hC0 -> halt=1 permanently, mem_req=0, retired frozen; async reset pulse mid-EXEC -> outputs clear immediately, no w_we pulse.
